// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Round-robin arbiter and 3-cycle sequencer in front of the single-port,
//   byte-addressed data memory. The memory has a combinational read and a clocked write.
//   Requester 0 is the CPU load/store path. Requester 1 is the debug/program loader.
//   The block checks alignment, pulses the memory write enable for exactly one cycle,
//   and sign-extends byte/half loads. The memory returns those zero-extended.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | wait for a request; grant the winner combinationally, latch its fields
//   ACCESS | drive memory from latched fields; write pulse or capture load data
//   RESP   | rvalid to owner with registered rdata/err; update round-robin pointer
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   req[1:0], we[1:0]    per-requester request and store flag
//   addr[63:0]           addr[32i+31:32i] byte address of requester i
//   wdata[63:0]          wdata[32i+31:32i] store data of requester i, LSB-aligned
//   memsrc[5:0]          memsrc[3i+2:3i]: [1:0] 00 byte, 01 half, 1x word; [2] unsigned load
//   gnt[1:0]             one-hot pulse, request accepted this edge
//   rvalid[1:0]          one-hot pulse, transaction complete
//   rdata[31:0], err     load result / misalignment flag, valid with rvalid
//   mem_addr, mem_wdata, mem_we, mem_src, mem_rdata   memory port

module data_mem_arbiter #(
    parameter int A_WIDTH = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [5:0]  memsrc,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_src,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic               rr_last_q, rr_last_d;
    logic               owner_q,   owner_d;
    logic               we_q,      we_d;
    logic [A_WIDTH-1:0] addr_q,    addr_d;
    logic [31:0]        wdata_q,   wdata_d;
    logic [2:0]         src_q,     src_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic               err_q,     err_d;

    logic        win;
    logic        is_word;
    logic        is_half;
    logic        misalign;
    logic        sext;
    logic [31:0] load_ext;

    // Address bits above A_WIDTH are never forwarded to the memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr[63:32+A_WIDTH], addr[31:A_WIDTH]};

    // Single requester wins outright; on a tie the one that did not go last wins.
    assign win = (req == 2'b11) ? ~rr_last_q : req[1];

    assign gnt = (state_q == S_IDLE && req != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign is_word  = src_q[1];
    assign is_half  = ~src_q[1] & src_q[0];
    assign misalign = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
    assign sext     = ~src_q[2];

    always_comb begin
        load_ext = mem_rdata;
        if (is_half) begin
            load_ext = {{16{sext & mem_rdata[15]}}, mem_rdata[15:0]};
        end else if (!is_word) begin
            load_ext = {{24{sext & mem_rdata[7]}}, mem_rdata[7:0]};
        end
    end

    // Memory-side fields come straight from the latches, which only change on a
    // grant, so they naturally hold the last ACCESS values between transactions.
    assign mem_addr  = {{(32-A_WIDTH){1'b0}}, addr_q};
    assign mem_wdata = wdata_q;
    assign mem_src   = src_q[1] ? {src_q[2], 2'b10} : src_q;
    // Combinational so that an async reset mid-ACCESS drops the write at once.
    assign mem_we    = (state_q == S_ACCESS) & we_q & ~misalign;

    assign rvalid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = rdata_q;
    assign err    = err_q;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        src_d     = src_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = win;
                    we_d    = win ? we[1] : we[0];
                    addr_d  = win ? addr[32+A_WIDTH-1:32] : addr[A_WIDTH-1:0];
                    wdata_d = win ? wdata[63:32] : wdata[31:0];
                    src_d   = win ? memsrc[5:3] : memsrc[2:0];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                err_d   = misalign;
                rdata_d = (misalign || we_q) ? 32'h0 : load_ext;
            end
            S_RESP: begin
                state_d   = S_IDLE;
                rr_last_d = owner_q;
                rdata_d   = 32'h0;
                err_d     = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            src_q     <= 3'b000;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            src_q     <= src_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule
